ddr_cmd_scheduler: RTL and testbench



---
 rtl/ddr_cmd_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_ddr_cmd_scheduler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ddr_cmd_scheduler.sv
//------------------------------------------------------------------------------
// Module   : ddr_cmd_scheduler
// Purpose  : DDR3 command scheduler with bank tracking, timing counters and
//            periodic refresh. Define DDR_SCHED_AUTO_PRE_EN for a closed-page policy.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ddr_cmd_scheduler #(
    parameter int ROW_W  = 14,
    parameter int BA_W   = 3,
    parameter int COL_W  = 10,
    parameter int T_INIT = 200,
    parameter int T_RCD  = 5,
    parameter int T_RP   = 5,
    parameter int T_RAS  = 15,
    parameter int T_CCD  = 4,
    parameter int T_RFC  = 64,
    parameter int T_REFI = 3120
) (
    input  logic             ck_t,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [BA_W-1:0]  req_ba,
    input  logic [ROW_W-1:0] req_row,
    input  logic [COL_W-1:0] req_col,
    output logic             cke,
    output logic             cs_n,
    output logic             ras_n,
    output logic             cas_n,
    output logic             we_n,
    output logic [ROW_W-1:0] a,
    output logic [BA_W-1:0]  ba,
    output logic             odt,
    output logic             rd_issue,
    output logic             wr_issue,
    output logic             init_done
);

    localparam int NBANK = 2 ** BA_W;
    localparam int TW    = 16;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_DES = 4'b1111;
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_PRE, S_WAIT_RP, S_ACT,
        S_WAIT_RCD, S_RW, S_PREA, S_REF, S_WAIT_RFC
    } state_t;

    state_t             state_q, state_d, st;
    logic [TW-1:0]      init_cnt_q, init_cnt_d;
    logic [TW-1:0]      refi_q, refi_d;
    logic               ref_pend_q, ref_pend_d;
    logic               ref_path_q, ref_path_d;
    logic [TW-1:0]      trcd_q, trcd_d, trp_q, trp_d, tras_q, tras_d;
    logic [TW-1:0]      tccd_q, tccd_d, trfc_q, trfc_d;
    logic [1:0]         odt_cnt_q, odt_cnt_d;
    logic [NBANK-1:0]   bank_open_q, bank_open_d;
    logic [ROW_W-1:0]   open_row_q [NBANK];
    logic [ROW_W-1:0]   open_row_d [NBANK];
    logic               lat_write_q, lat_write_d;
    logic [BA_W-1:0]    lat_ba_q, lat_ba_d;
    logic [ROW_W-1:0]   lat_row_q, lat_row_d;
    logic [COL_W-1:0]   lat_col_q, lat_col_d;
    logic [3:0]         cmd_q, cmd_d;
    logic [ROW_W-1:0]   a_q, a_d;
    logic [BA_W-1:0]    ba_q, ba_d;
    logic               cke_q, cke_d, odt_q, odt_d;
    logic               rd_issue_q, rd_issue_d, wr_issue_q, wr_issue_d;
    logic               init_done_q, init_done_d, req_ready_q, req_ready_d;

    logic               hs, cur_write;
    logic [BA_W-1:0]    cur_ba;
    logic [ROW_W-1:0]   cur_row;
    logic [COL_W-1:0]   cur_col;

    function automatic logic [TW-1:0] dec(input logic [TW-1:0] t);
        return (t == '0) ? t : t - TW'(1);
    endfunction

    // A timer loaded at command cycle C reads 1 in cycle C+T-1, so a command
    // decided then lands on the bus exactly T cycles after the earlier one.
    function automatic logic expired(input logic [TW-1:0] t);
        return t <= TW'(1);
    endfunction

    always_comb begin
        hs          = req_valid & req_ready_q;
        cur_write   = hs ? req_write : lat_write_q;
        cur_ba      = hs ? req_ba    : lat_ba_q;
        cur_row     = hs ? req_row   : lat_row_q;
        cur_col     = hs ? req_col   : lat_col_q;

        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        refi_d      = refi_q;
        ref_pend_d  = ref_pend_q;
        ref_path_d  = ref_path_q;
        trcd_d      = dec(trcd_q);
        trp_d       = dec(trp_q);
        tras_d      = dec(tras_q);
        tccd_d      = dec(tccd_q);
        trfc_d      = dec(trfc_q);
        bank_open_d = bank_open_q;
        open_row_d  = open_row_q;
        lat_write_d = cur_write;
        lat_ba_d    = cur_ba;
        lat_row_d   = cur_row;
        lat_col_d   = cur_col;
        cmd_d       = CMD_NOP;
        a_d         = '0;
        ba_d        = '0;
        cke_d       = cke_q;
        init_done_d = init_done_q;
        rd_issue_d  = 1'b0;
        wr_issue_d  = 1'b0;
        odt_d       = (odt_cnt_q != 2'd0);
        odt_cnt_d   = (odt_cnt_q != 2'd0) ? odt_cnt_q - 2'd1 : 2'd0;

        // Resolve waiting states that are ready this cycle so the command
        // goes out on the very next bus cycle.
        st = state_q;
        if (st == S_IDLE) begin
            if (ref_pend_q)
                st = (|bank_open_q) ? S_PREA : S_REF;
            else if (hs) begin
                if (!bank_open_q[req_ba])
                    st = S_ACT;
                else if (open_row_q[req_ba] == req_row)
                    st = S_RW;
                else
                    st = S_PRE;
            end
        end
        if (st == S_WAIT_RP && expired(trp_q))
            st = ref_path_q ? S_REF : S_ACT;
        if (st == S_WAIT_RCD && expired(trcd_q))
            st = S_RW;
        state_d = st;

        case (st)
            S_INIT: begin
                cmd_d = CMD_DES;
                if (init_cnt_q == TW'(T_INIT - 1)) begin
                    state_d     = S_IDLE;
                    cke_d       = 1'b1;
                    init_done_d = 1'b1;
                    cmd_d       = CMD_NOP;
                end else begin
                    init_cnt_d = init_cnt_q + TW'(1);
                end
            end
            S_PRE: begin
                if (expired(tras_q)) begin
                    cmd_d               = CMD_PRE;
                    ba_d                = cur_ba;
                    bank_open_d[cur_ba] = 1'b0;
                    trp_d               = TW'(T_RP);
                    state_d             = S_WAIT_RP;
                end
            end
            S_ACT: begin
                if (expired(trp_q)) begin
                    cmd_d               = CMD_ACT;
                    a_d                 = cur_row;
                    ba_d                = cur_ba;
                    bank_open_d[cur_ba] = 1'b1;
                    open_row_d[cur_ba]  = cur_row;
                    trcd_d              = TW'(T_RCD);
                    tras_d              = TW'(T_RAS);
                    state_d             = S_WAIT_RCD;
                end
            end
            S_RW: begin
                if (expired(tccd_q)) begin
                    cmd_d              = cur_write ? CMD_WR : CMD_RD;
                    a_d[COL_W-1:0]     = cur_col;
                    ba_d               = cur_ba;
`ifdef DDR_SCHED_AUTO_PRE_EN
                    a_d[10]             = 1'b1;
                    bank_open_d[cur_ba] = 1'b0;
                    trp_d               = TW'(T_RP + T_CCD);
`else
                    a_d[10]             = 1'b0;
`endif
                    tccd_d             = TW'(T_CCD);
                    rd_issue_d         = ~cur_write;
                    wr_issue_d         = cur_write;
                    if (cur_write) begin
                        odt_d     = 1'b1;
                        odt_cnt_d = 2'd3;
                    end
                    state_d            = S_IDLE;
                end
            end
            S_PREA: begin
                if (expired(tras_q)) begin
                    cmd_d       = CMD_PRE;
                    a_d[10]     = 1'b1;
                    bank_open_d = '0;
                    trp_d       = TW'(T_RP);
                    ref_path_d  = 1'b1;
                    state_d     = S_WAIT_RP;
                end
            end
            S_REF: begin
                if (expired(trp_q)) begin
                    cmd_d      = CMD_REF;
                    trfc_d     = TW'(T_RFC);
                    ref_pend_d = 1'b0;
                    ref_path_d = 1'b0;
                    state_d    = S_WAIT_RFC;
                end
            end
            S_WAIT_RFC: begin
                if (expired(trfc_q))
                    state_d = S_IDLE;
            end
            default: ;
        endcase

        // Evaluated after the REF clear so an expiry in the same cycle is kept.
        if (state_q != S_INIT) begin
            if (refi_q == '0) begin
                ref_pend_d = 1'b1;
                refi_d     = TW'(T_REFI);
            end else begin
                refi_d = refi_q - TW'(1);
            end
        end

        req_ready_d = (state_d == S_IDLE) && !ref_pend_d && !hs;
    end

    always_ff @(posedge ck_t or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            refi_q      <= TW'(T_REFI);
            ref_pend_q  <= 1'b0;
            ref_path_q  <= 1'b0;
            trcd_q      <= '0;
            trp_q       <= '0;
            tras_q      <= '0;
            tccd_q      <= '0;
            trfc_q      <= '0;
            odt_cnt_q   <= '0;
            bank_open_q <= '0;
            open_row_q  <= '{default: '0};
            lat_write_q <= 1'b0;
            lat_ba_q    <= '0;
            lat_row_q   <= '0;
            lat_col_q   <= '0;
            cmd_q       <= CMD_DES;
            a_q         <= '0;
            ba_q        <= '0;
            cke_q       <= 1'b0;
            odt_q       <= 1'b0;
            rd_issue_q  <= 1'b0;
            wr_issue_q  <= 1'b0;
            init_done_q <= 1'b0;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            refi_q      <= refi_d;
            ref_pend_q  <= ref_pend_d;
            ref_path_q  <= ref_path_d;
            trcd_q      <= trcd_d;
            trp_q       <= trp_d;
            tras_q      <= tras_d;
            tccd_q      <= tccd_d;
            trfc_q      <= trfc_d;
            odt_cnt_q   <= odt_cnt_d;
            bank_open_q <= bank_open_d;
            open_row_q  <= open_row_d;
            lat_write_q <= lat_write_d;
            lat_ba_q    <= lat_ba_d;
            lat_row_q   <= lat_row_d;
            lat_col_q   <= lat_col_d;
            cmd_q       <= cmd_d;
            a_q         <= a_d;
            ba_q        <= ba_d;
            cke_q       <= cke_d;
            odt_q       <= odt_d;
            rd_issue_q  <= rd_issue_d;
            wr_issue_q  <= wr_issue_d;
            init_done_q <= init_done_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign {cs_n, ras_n, cas_n, we_n} = cmd_q;
    assign a         = a_q;
    assign ba        = ba_q;
    assign cke       = cke_q;
    assign odt       = odt_q;
    assign rd_issue  = rd_issue_q;
    assign wr_issue  = wr_issue_q;
    assign init_done = init_done_q;
    assign req_ready = req_ready_q;

endmodule

`default_nettype wire

// File: tb/tb_ddr_cmd_scheduler.sv
//------------------------------------------------------------------------------
// Module   : tb_ddr_cmd_scheduler
// Purpose  : Directed self-checking bench for ddr_cmd_scheduler (default build).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ddr_cmd_scheduler;

    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [26:0] RST_VEC = {1'b0, 4'b1111, 14'd0, 3'd0, 5'd0};

    logic        ck_t, reset_n;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_ba;
    logic [13:0] req_row;
    logic [9:0]  req_col;
    logic        cke, cs_n, ras_n, cas_n, we_n;
    logic [13:0] a;
    logic [2:0]  ba;
    logic        odt, rd_issue, wr_issue, init_done;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    ddr_cmd_scheduler dut (
        .ck_t      (ck_t),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_ba    (req_ba),
        .req_row   (req_row),
        .req_col   (req_col),
        .cke       (cke),
        .cs_n      (cs_n),
        .ras_n     (ras_n),
        .cas_n     (cas_n),
        .we_n      (we_n),
        .a         (a),
        .ba        (ba),
        .odt       (odt),
        .rd_issue  (rd_issue),
        .wr_issue  (wr_issue),
        .init_done (init_done)
    );

    initial begin
        ck_t = 1'b0;
        forever #5 ck_t = ~ck_t;
    end

    always @(posedge ck_t) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [26:0] out_vec();
        return {cke, cs_n, ras_n, cas_n, we_n, a, ba, odt, req_ready, rd_issue, wr_issue, init_done};
    endfunction

    task automatic run_init(input string tag);
        int   rel;
        int   k = 0;
        logic cs_high = 1'b1;
        reset_n = 1'b1;
        rel = cyc;
        while (!cke && k < 1000) begin
            if (!cs_n) cs_high = 1'b0;
            @(negedge ck_t);
            k++;
        end
        check({tag, " cke low cycles"}, cyc - rel, 200);
        check({tag, " cs_n high in init"}, 32'(cs_high), 1);
        check({tag, " init_done"}, 32'(init_done), 1);
        check({tag, " req_ready"}, 32'(req_ready), 1);
        check({tag, " nop cs_n"}, 32'(cs_n), 0);
    endtask

    task automatic send_req(input logic w, input logic [2:0] b, input logic [13:0] r,
                            input logic [9:0] c, output int hc);
        int k = 0;
        req_valid = 1'b1;
        req_write = w;
        req_ba    = b;
        req_row   = r;
        req_col   = c;
        while (!req_ready && k < 500) begin
            @(negedge ck_t);
            k++;
        end
        check("handshake", 32'(req_ready), 1);
        hc = cyc;
        @(negedge ck_t);
        req_valid = 1'b0;
    endtask

    task automatic expect_cmd(input string tag, input logic [3:0] code, input int exp_cyc,
                              input logic [2:0] exp_ba, input logic [13:0] exp_a, output int at);
        int k = 0;
        while (!(cs_n == 1'b0 && {ras_n, cas_n, we_n} != 3'b111) && k < 300) begin
            @(negedge ck_t);
            k++;
        end
        check({tag, " seen"}, 32'(k < 300), 1);
        check({tag, " cmd"}, {28'd0, cs_n, ras_n, cas_n, we_n}, {28'd0, code});
        check({tag, " cycle"}, cyc, exp_cyc);
        check({tag, " ba"}, {29'd0, ba}, {29'd0, exp_ba});
        check({tag, " a"}, {18'd0, a}, {18'd0, exp_a});
        check({tag, " rd_issue"}, 32'(rd_issue), 32'(code == C_RD));
        check({tag, " wr_issue"}, 32'(wr_issue), 32'(code == C_WR));
        check({tag, " odt"}, 32'(odt), 32'(code == C_WR));
        at = cyc;
        @(negedge ck_t);
    endtask

    initial begin
        int h, t_act, t_rd, t_wr, t_pre, t_ref, q, k;

        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_ba    = '0;
        req_row   = '0;
        req_col   = '0;
        repeat (3) @(negedge ck_t);
        check("reset outputs", 32'(out_vec()), 32'(RST_VEC));
        run_init("init1");

        // Read to closed bank 2
        send_req(1'b0, 3'd2, 14'h123, 10'h040, h);
        expect_cmd("rd closed ACT", C_ACT, h + 1, 3'd2, 14'h123, t_act);
        expect_cmd("rd closed RD", C_RD, h + 6, 3'd2, 14'h040, t_rd);

        // Row hit write, held off by tCCD
        send_req(1'b1, 3'd2, 14'h123, 10'h048, h);
        expect_cmd("hit WR", C_WR, t_rd + 4, 3'd2, 14'h048, t_wr);
        check("wr_issue drop", 32'(wr_issue), 0);
        for (int i = 0; i < 3; i++) begin
            check("odt tail", 32'(odt), 1);
            @(negedge ck_t);
        end
        check("odt off", 32'(odt), 0);

        // Conflict right after an ACT: PRE waits for tRAS
        send_req(1'b0, 3'd5, 14'h010, 10'h008, h);
        expect_cmd("b5 ACT", C_ACT, h + 1, 3'd5, 14'h010, t_act);
        expect_cmd("b5 RD", C_RD, t_act + 5, 3'd5, 14'h008, t_rd);
        send_req(1'b0, 3'd5, 14'h200, 10'h010, h);
        expect_cmd("conf PRE", C_PRE, t_act + 15, 3'd5, 14'h000, t_pre);
        expect_cmd("conf ACT", C_ACT, t_pre + 5, 3'd5, 14'h200, t_act);
        expect_cmd("conf RD", C_RD, t_act + 5, 3'd5, 14'h010, t_rd);

        // Bank 2 row is still open: hit read
        send_req(1'b0, 3'd2, 14'h123, 10'h060, h);
        expect_cmd("hit RD", C_RD, (h + 1 > t_rd + 4) ? h + 1 : t_rd + 4, 3'd2, 14'h060, t_rd);

        // Refresh expiry with bank 2 open and a request waiting
        k = 0;
        while (req_ready && k < 4000) begin
            @(negedge ck_t);
            k++;
        end
        check("refresh expiry seen", 32'(k < 4000), 1);
        q = cyc;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_ba    = 3'd2;
        req_row   = 14'h123;
        req_col   = 10'h050;
        check("ref ready low", 32'(req_ready), 0);
        expect_cmd("PREA", C_PRE, q + 1, 3'd0, 14'h400, t_pre);
        expect_cmd("REF", C_REF, t_pre + 5, 3'd0, 14'h000, t_ref);
        send_req(1'b0, 3'd2, 14'h123, 10'h050, h);
        check("accept after tRFC", h - t_ref, 64);
        expect_cmd("post-ref ACT", C_ACT, h + 1, 3'd2, 14'h123, t_act);
        expect_cmd("post-ref RD", C_RD, h + 6, 3'd2, 14'h050, t_rd);

        // Reset during WAIT_RCD
        send_req(1'b0, 3'd1, 14'h055, 10'h004, h);
        expect_cmd("pre-rst ACT", C_ACT, h + 1, 3'd1, 14'h055, t_act);
        reset_n = 1'b0;
        #1;
        check("async reset outputs", 32'(out_vec()), 32'(RST_VEC));
        repeat (3) @(negedge ck_t);
        check("held reset outputs", 32'(out_vec()), 32'(RST_VEC));
        run_init("init2");
        send_req(1'b0, 3'd1, 14'h055, 10'h004, h);
        expect_cmd("re-init ACT", C_ACT, h + 1, 3'd1, 14'h055, t_act);
        expect_cmd("re-init RD", C_RD, h + 6, 3'd1, 14'h004, t_rd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
